// File: rtl/div_seq_pkg.sv
// Shared definitions for the sequential 32-bit integer divider:
// op bit positions, one-hot state encoding and the decided special-case results.
package div_seq_pkg;

  localparam int DIV_OP_SIGNED = 0;
  localparam int DIV_OP_MOD    = 1;
  localparam int DIV_ITERS     = 32;

  localparam logic [31:0] DIV0_QUO = 32'hFFFF_FFFF;
  localparam logic [31:0] OVF_QUO  = 32'h8000_0000;

  typedef enum logic [3:0] {
    IDLE = 4'b0001,
    ITER = 4'b0010,
    FIX  = 4'b0100,
    DONE = 4'b1000
  } div_state_e;

  // Two's-complement negate when neg is set; used for abs() on capture and sign fix-up.
  function automatic logic [31:0] neg_if(input logic [31:0] val, input logic neg);
    logic [31:0] res;
    if (neg) begin
      res = 32'd0 - val;
    end else begin
      res = val;
    end
    return res;
  endfunction

endpackage

// File: rtl/div_iter_step.sv
// One radix-2 restoring division step: shift the next dividend bit into the
// partial remainder and subtract the divisor when it fits.
module div_iter_step
  import div_seq_pkg::*;
(
  input  logic [31:0] rem,
  input  logic [31:0] quo,
  input  logic [31:0] divisor,
  output logic [31:0] rem_next,
  output logic [31:0] quo_next
);

  logic [32:0] shifted_s;
  logic [33:0] trial_s;
  logic        fits_s;

  // Trial subtraction is kept one bit wider than the shifted remainder so the
  // borrow is unambiguous even for a divisor of 0x80000000.
  always_comb begin
    shifted_s = {rem, quo[31]};
    trial_s   = {1'b0, shifted_s} - {2'b00, divisor};
    fits_s    = ~trial_s[33];
    if (fits_s) begin
      rem_next = trial_s[31:0];
    end else begin
      rem_next = shifted_s[31:0];
    end
    quo_next = {quo[30:0], fits_s};
  end

endmodule

// File: rtl/div_seq.sv
// Multi-cycle divide sequencer for div.w/mod.w/div.wu/mod.wu: captures operands,
// iterates a restoring datapath 32 times, fixes signs/special cases, holds the result.
module div_seq
  import div_seq_pkg::*;
#(
  parameter bit EARLY_ZERO = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        div_valid,
  output logic        div_ready,
  input  logic [1:0]  div_op,
  input  logic [31:0] div_src1,
  input  logic [31:0] div_src2,
  input  logic        cancel,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [31:0] div_result
);

  localparam logic [4:0] CNT_LAST = 5'(DIV_ITERS - 1);

  div_state_e  state_r;
  div_state_e  state_next_s;
  logic [4:0]  cnt_r;
  logic [31:0] rem_r;
  logic [31:0] quo_r;
  logic [31:0] divisor_r;
  logic [31:0] dividend_r;
  logic [31:0] result_r;
  logic        mod_r;
  logic        quo_neg_r;
  logic        rem_neg_r;
  logic        div0_r;
  logic        ovf_r;

  logic        accept_s;
  logic        sgn1_s;
  logic        sgn2_s;
  logic        div0_s;
  logic        ovf_s;
  logic        early_s;
  logic [31:0] rem_step_s;
  logic [31:0] quo_step_s;
  logic [31:0] fix_result_s;
  logic        ready_s;
  logic        valid_s;

  div_iter_step u_step (
    .rem      (rem_r),
    .quo      (quo_r),
    .divisor  (divisor_r),
    .rem_next (rem_step_s),
    .quo_next (quo_step_s)
  );

  // Operand classification at the handshake; signs only matter for signed ops.
  always_comb begin
    sgn1_s   = div_op[DIV_OP_SIGNED] & div_src1[31];
    sgn2_s   = div_op[DIV_OP_SIGNED] & div_src2[31];
    div0_s   = (div_src2 == 32'd0);
    ovf_s    = div_op[DIV_OP_SIGNED] & (div_src1 == OVF_QUO) & (div_src2 == DIV0_QUO);
    early_s  = EARLY_ZERO & (div0_s | ovf_s);
    accept_s = (state_r == IDLE) & div_valid & ~cancel;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic; cancel overrides every state.
  always_comb begin
    state_next_s = state_r;
    if (cancel) begin
      state_next_s = IDLE;
    end else begin
      case (state_r)
        IDLE: begin
          if (div_valid) begin
            state_next_s = early_s ? FIX : ITER;
          end else begin
            state_next_s = IDLE;
          end
        end
        ITER: begin
          if (cnt_r == 5'd0) begin
            state_next_s = FIX;
          end else begin
            state_next_s = ITER;
          end
        end
        FIX:  state_next_s = DONE;
        DONE: begin
          if (res_ready) begin
            state_next_s = IDLE;
          end else begin
            state_next_s = DONE;
          end
        end
        default: state_next_s = IDLE;
      endcase
    end
  end

  // Handshake outputs decode straight from the one-hot state flops.
  always_comb begin
    ready_s = 1'b0;
    valid_s = 1'b0;
    case (state_r)
      IDLE:    ready_s = 1'b1;
      DONE:    valid_s = 1'b1;
      ITER:    ready_s = 1'b0;
      FIX:     ready_s = 1'b0;
      default: ready_s = 1'b0;
    endcase
  end

  // Operand capture and iteration datapath.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_r      <= 5'd0;
      rem_r      <= 32'd0;
      quo_r      <= 32'd0;
      divisor_r  <= 32'd0;
      dividend_r <= 32'd0;
      mod_r      <= 1'b0;
      quo_neg_r  <= 1'b0;
      rem_neg_r  <= 1'b0;
      div0_r     <= 1'b0;
      ovf_r      <= 1'b0;
    end else if (accept_s) begin
      cnt_r      <= CNT_LAST;
      rem_r      <= 32'd0;
      quo_r      <= neg_if(div_src1, sgn1_s);
      divisor_r  <= neg_if(div_src2, sgn2_s);
      dividend_r <= div_src1;
      mod_r      <= div_op[DIV_OP_MOD];
      quo_neg_r  <= sgn1_s ^ sgn2_s;
      rem_neg_r  <= sgn1_s;
      div0_r     <= div0_s;
      ovf_r      <= ovf_s;
    end else if (state_r == ITER) begin
      cnt_r      <= cnt_r - 5'd1;
      rem_r      <= rem_step_s;
      quo_r      <= quo_step_s;
    end
  end

  // Sign fix-up and special-case override of the raw quotient/remainder.
  always_comb begin
    if (div0_r) begin
      fix_result_s = mod_r ? dividend_r : DIV0_QUO;
    end else if (ovf_r) begin
      fix_result_s = mod_r ? 32'd0 : OVF_QUO;
    end else if (mod_r) begin
      fix_result_s = neg_if(rem_r, rem_neg_r);
    end else begin
      fix_result_s = neg_if(quo_r, quo_neg_r);
    end
  end

  // Result register: loaded only by a FIX cycle that is not being flushed.
  always_ff @(posedge clk) begin
    if (reset) begin
      result_r <= 32'd0;
    end else if ((state_r == FIX) && !cancel) begin
      result_r <= fix_result_s;
    end
  end

  assign div_ready  = ready_s;
  assign res_valid  = valid_s;
  assign div_result = result_r;

endmodule

// File: tb/tb_div_seq.sv
// Randomized and directed self-checking bench for div_seq; one instance uses the
// short special-case latency, the other always runs the full iteration count.
module tb_div_seq;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [1:0]  div_op = 2'd0;
  logic [31:0] src1 = 32'd0;
  logic [31:0] src2 = 32'd0;

  logic        valid_e = 1'b0, cancel_e = 1'b0, rr_e = 1'b0;
  logic        ready_e, rv_e;
  logic [31:0] res_e;
  logic        valid_f = 1'b0, cancel_f = 1'b0, rr_f = 1'b0;
  logic        ready_f, rv_f;
  logic [31:0] res_f;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  div_seq #(.EARLY_ZERO(1'b1)) dut_early (
    .clk(clk), .reset(reset), .div_valid(valid_e), .div_ready(ready_e),
    .div_op(div_op), .div_src1(src1), .div_src2(src2), .cancel(cancel_e),
    .res_valid(rv_e), .res_ready(rr_e), .div_result(res_e));

  div_seq #(.EARLY_ZERO(1'b0)) dut_full (
    .clk(clk), .reset(reset), .div_valid(valid_f), .div_ready(ready_f),
    .div_op(div_op), .div_src1(src1), .div_src2(src2), .cancel(cancel_f),
    .res_valid(rv_f), .res_ready(rr_f), .div_result(res_f));

  // Reference: plain integer semantics plus the architected special cases.
  function automatic logic [31:0] ref_result(input logic [1:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
    logic signed [31:0] sa, sb;
    sa = a;
    sb = b;
    if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
    if (op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return op[1] ? 32'd0 : 32'h8000_0000;
    if (op[0]) return op[1] ? 32'(sa % sb) : 32'(sa / sb);
    return op[1] ? a % b : a / b;
  endfunction

  // Edges from the accepting edge to the first edge after which res_valid is high.
  function automatic int ref_lat(input bit full, input logic [1:0] op, input logic [31:0] a,
                                 input logic [31:0] b);
    if (!full && (b == 32'd0 || (op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) return 1;
    return 33;
  endfunction

  function automatic logic get_ready(input bit full);
    return full ? ready_f : ready_e;
  endfunction

  function automatic logic get_rv(input bit full);
    return full ? rv_f : rv_e;
  endfunction

  function automatic logic [31:0] get_res(input bit full);
    return full ? res_f : res_e;
  endfunction

  // Present an op and hold it until the accepting edge (bounded).
  task automatic present(input bit full, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, output bit ok);
    div_op = op; src1 = a; src2 = b;
    ok = 1'b0;
    if (full) valid_f = 1'b1; else valid_e = 1'b1;
    for (int i = 0; i < 20 && !ok; i++) begin
      ok = get_ready(full);
      @(posedge clk); #1;
    end
    valid_f = 1'b0; valid_e = 1'b0;
  endtask

  // Count edges until res_valid is seen; -1 on timeout.
  task automatic wait_res(input bit full, output int lat);
    lat = -1;
    for (int i = 1; i <= 60; i++) begin
      @(posedge clk); #1;
      if (get_rv(full)) begin lat = i; break; end
    end
  endtask

  task automatic consume(input bit full);
    if (full) rr_f = 1'b1; else rr_e = 1'b1;
    @(posedge clk); #1;
    rr_f = 1'b0; rr_e = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    for (int k = 0; k < 2; k++) begin
      total++;
      if (get_ready(k[0]) !== 1'b1) begin bad++; $display("FAIL reset_ready inst=%0d got=%b want=1", k, get_ready(k[0])); end
      total++;
      if (get_rv(k[0]) !== 1'b0) begin bad++; $display("FAIL reset_valid inst=%0d got=%b want=0", k, get_rv(k[0])); end
      total++;
      if (get_res(k[0]) !== 32'd0) begin bad++; $display("FAIL reset_result inst=%0d got=%h want=0", k, get_res(k[0])); end
    end
  endtask

  bit          dir_full [13] = '{0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 1, 0, 0};
  logic [1:0]  dir_op   [13] = '{2'b00, 2'b10, 2'b01, 2'b11, 2'b01, 2'b11, 2'b01, 2'b11,
                                 2'b00, 2'b10, 2'b00, 2'b01, 2'b11};
  logic [31:0] dir_a    [13] = '{32'd100, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF9,
                                 32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000,
                                 32'd1234, 32'd1234, 32'd1234, 32'd7, 32'hFFFF_FFF9};
  logic [31:0] dir_b    [13] = '{32'd7, 32'd7, 32'd2, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                                 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};

  task automatic test_directed();
    bit ok;
    int lat;
    logic [31:0] want;
    for (int i = 0; i < 13; i++) begin
      present(dir_full[i], dir_op[i], dir_a[i], dir_b[i], ok);
      total++;
      if (!ok) begin bad++; $display("FAIL dir_accept #%0d got=not_accepted want=accepted", i); end
      wait_res(dir_full[i], lat);
      want = ref_result(dir_op[i], dir_a[i], dir_b[i]);
      total++;
      if (get_res(dir_full[i]) !== want) begin
        bad++; $display("FAIL dir_result #%0d got=%h want=%h", i, get_res(dir_full[i]), want);
      end
      total++;
      if (lat != ref_lat(dir_full[i], dir_op[i], dir_a[i], dir_b[i])) begin
        bad++; $display("FAIL dir_latency #%0d got=%0d want=%0d", i, lat,
                        ref_lat(dir_full[i], dir_op[i], dir_a[i], dir_b[i]));
      end
      consume(dir_full[i]);
    end
  endtask

  task automatic test_random();
    bit ok, full;
    int lat;
    logic [1:0] op;
    logic [31:0] a, b, want;
    for (int i = 0; i < 40; i++) begin
      full = i[0];
      op = 2'($urandom_range(0, 3));
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 9))
        0: b = 32'd0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: b = $urandom_range(1, 15);
        3: b = 32'd0 - 32'($urandom_range(1, 15));
        4: a = $urandom_range(0, 100);
        default: ;
      endcase
      present(full, op, a, b, ok);
      wait_res(full, lat);
      want = ref_result(op, a, b);
      total++;
      if (!ok || get_res(full) !== want) begin
        bad++; $display("FAIL rnd_result op=%b a=%h b=%h got=%h want=%h", op, a, b, get_res(full), want);
      end
      total++;
      if (lat != ref_lat(full, op, a, b)) begin
        bad++; $display("FAIL rnd_latency op=%b a=%h b=%h got=%0d want=%0d", op, a, b, lat, ref_lat(full, op, a, b));
      end
      consume(full);
    end
  endtask

  task automatic test_cancel();
    bit ok;
    int lat, seen;
    present(1'b0, 2'b00, 32'd100, 32'd7, ok);
    repeat (9) begin @(posedge clk); #1; end
    cancel_e = 1'b1;
    @(posedge clk); #1;
    cancel_e = 1'b0;
    total++;
    if (ready_e !== 1'b1 || rv_e !== 1'b0) begin
      bad++; $display("FAIL cancel_iter ready=%b valid=%b want ready=1 valid=0", ready_e, rv_e);
    end
    seen = 0;
    repeat (40) begin @(posedge clk); #1; if (rv_e) seen++; end
    total++;
    if (seen != 0) begin bad++; $display("FAIL cancel_no_result got=%0d want=0 valid cycles", seen); end
    present(1'b0, 2'b00, 32'd9, 32'd3, ok);
    wait_res(1'b0, lat);
    total++;
    if (!ok || res_e !== 32'd3 || lat != 33) begin
      bad++; $display("FAIL after_cancel got=%h lat=%0d want=3 lat=33", res_e, lat);
    end
    consume(1'b0);
    // Cancel together with a request in IDLE: nothing may be captured.
    div_op = 2'b00; src1 = 32'd50; src2 = 32'd5;
    valid_e = 1'b1; cancel_e = 1'b1;
    @(posedge clk); #1;
    valid_e = 1'b0; cancel_e = 1'b0;
    total++;
    if (ready_e !== 1'b1) begin bad++; $display("FAIL cancel_idle ready got=%b want=1", ready_e); end
    seen = 0;
    repeat (40) begin @(posedge clk); #1; if (rv_e) seen++; end
    total++;
    if (seen != 0) begin bad++; $display("FAIL cancel_idle_result got=%0d want=0 valid cycles", seen); end
    // Cancel while the result is waiting, with and without res_ready.
    for (int k = 0; k < 2; k++) begin
      present(1'b1, 2'b01, 32'hFFFF_FF00, 32'd16, ok);
      wait_res(1'b1, lat);
      cancel_f = 1'b1; rr_f = k[0];
      @(posedge clk); #1;
      cancel_f = 1'b0; rr_f = 1'b0;
      total++;
      if (ready_f !== 1'b1 || rv_f !== 1'b0) begin
        bad++; $display("FAIL cancel_done rr=%0d ready=%b valid=%b want ready=1 valid=0", k, ready_f, rv_f);
      end
    end
  endtask

  task automatic test_hold();
    bit ok;
    int lat, unstable;
    logic [31:0] want;
    present(1'b0, 2'b00, 32'd1000, 32'd10, ok);
    want = ref_result(2'b00, 32'd1000, 32'd10);
    // A request arriving mid-operation must be ignored.
    div_op = 2'b11; src1 = 32'h1234_5678; src2 = 32'd0; valid_e = 1'b1;
    repeat (5) begin @(posedge clk); #1; end
    valid_e = 1'b0;
    wait_res(1'b0, lat);
    total++;
    if (!ok || res_e !== want || lat + 5 != 33) begin
      bad++; $display("FAIL busy_ignore got=%h lat=%0d want=%h lat=33", res_e, lat + 5, want);
    end
    unstable = 0;
    repeat (5) begin
      @(posedge clk); #1;
      if (res_e !== want || ready_e !== 1'b0 || rv_e !== 1'b1) unstable++;
    end
    total++;
    if (unstable != 0) begin bad++; $display("FAIL hold_stable got=%0d want=0 bad cycles", unstable); end
    // Consume with a new request already waiting: no same-cycle re-accept.
    div_op = 2'b00; src1 = 32'd77; src2 = 32'd7;
    rr_e = 1'b1; valid_e = 1'b1;
    @(posedge clk); #1;
    rr_e = 1'b0;
    total++;
    if (ready_e !== 1'b1 || rv_e !== 1'b0) begin
      bad++; $display("FAIL consume_idle ready=%b valid=%b want ready=1 valid=0", ready_e, rv_e);
    end
    @(posedge clk); #1;
    valid_e = 1'b0;
    total++;
    if (ready_e !== 1'b0) begin bad++; $display("FAIL reaccept ready got=%b want=0", ready_e); end
    wait_res(1'b0, lat);
    total++;
    if (res_e !== 32'd11 || lat != 33) begin
      bad++; $display("FAIL reaccept_result got=%h lat=%0d want=0000000b lat=33", res_e, lat);
    end
    consume(1'b0);
  endtask

  task automatic test_reset_mid();
    bit ok;
    int lat, seen;
    present(1'b0, 2'b00, 32'd100, 32'd7, ok);
    wait_res(1'b0, lat);
    total++;
    if (res_e !== 32'd14) begin bad++; $display("FAIL pre_reset got=%h want=0000000e", res_e); end
    present(1'b1, 2'b00, 32'd100, 32'd7, ok);
    repeat (5) begin @(posedge clk); #1; end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    total++;
    if (rv_e !== 1'b0 || ready_e !== 1'b1 || res_e !== 32'd0) begin
      bad++; $display("FAIL reset_done valid=%b ready=%b res=%h want 0/1/0", rv_e, ready_e, res_e);
    end
    total++;
    if (ready_f !== 1'b1) begin bad++; $display("FAIL reset_iter ready got=%b want=1", ready_f); end
    seen = 0;
    repeat (40) begin @(posedge clk); #1; if (rv_f || rv_e) seen++; end
    total++;
    if (seen != 0) begin bad++; $display("FAIL reset_no_result got=%0d want=0 valid cycles", seen); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_cancel();
    test_hold();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/div_seq.md
Name: div_seq

Overview:
- Multi-cycle sequencer for 32-bit integer divide (div.w, mod.w, div.wu, mod.wu) in the EX stage, beside the single-cycle alu and its multiplier.
- Captures operands through a valid/ready handshake and runs a radix-2 restoring shift-subtract datapath for 32 iterations.
- Applies sign and special-case fix-up, then holds the result until the pipeline consumes it.
- Supports flush (cancel) from exception or branch recovery at any point.

Parameters:
- EARLY_ZERO, 1, 1 = divide-by-zero and signed overflow skip iterations (short latency); 0 = always full 32 iterations.

Ports:
- clk  in  1  core clock
- reset  in  1  synchronous, active-high reset
- div_valid  in  1  EX presents a divide op
- div_ready  out  1  sequencer can accept (state IDLE)
- div_op  in  2  [0]=signed, [1]=remainder (mod) vs quotient (div)
- div_src1  in  32  dividend (rj)
- div_src2  in  32  divisor (rk)
- cancel  in  1  flush; kills any in-flight op
- res_valid  out  1  result available
- res_ready  in  1  consumer takes result
- div_result  out  32  quotient or remainder per captured div_op

Behaviour:
- Reset: state=IDLE, div_ready=1, res_valid=0, div_result=0, all internal registers 0.
- States and transitions:
  - IDLE: accept on div_valid&div_ready&~cancel. Capture op, |src1|, |src2| (abs only when signed), quotient sign = s1^s2, remainder sign = s1, and the special flags. Go to ITER with counter=31, or straight to FIX if EARLY_ZERO and a special case applies.
  - ITER: one restoring step per cycle. {rem,quo} shifts left by 1; trial = rem - divisor (33-bit); if non-negative, rem=trial and the quotient LSB=1. The counter decrements; at counter==0 go to FIX.
  - FIX: negate quotient/remainder per the captured signs; apply special cases; register div_result; go to DONE.
  - DONE: res_valid=1. div_result is stable while res_valid&~res_ready. On res_ready go to IDLE; div_ready=1 the next cycle. There is no same-cycle re-accept.
- Latency: handshake at edge T; ITER during cycles T+1..T+32; FIX at T+33; res_valid high from T+34. Special cases with EARLY_ZERO=1: FIX at T+1, res_valid at T+2.
- Special cases (decided results):
  - Divisor 0: quotient 0xFFFFFFFF, remainder = original dividend, for signed and unsigned alike.
  - Signed 0x80000000 / 0xFFFFFFFF: quotient 0x80000000, remainder 0.
  - Remainder takes the dividend's sign; the quotient truncates toward zero.
- Cancel:
  - Asserted in any state, the next state is IDLE and res_valid drops the next cycle; no result is ever presented for the killed op.
  - Cancel with div_valid in IDLE: cancel wins, nothing is captured.
  - Cancel in DONE coincident with res_ready: the result counts as consumed, and the state returns to IDLE either way.
- Reset mid-operation behaves like cancel, and additionally clears div_result.
- div_valid is ignored outside IDLE. EX holds div_valid and operands until the handshake completes.

Decomposition:
- Shared package:
  - DIV_OP_SIGNED and DIV_OP_MOD bit indices.
  - State encoding IDLE/ITER/FIX/DONE (one-hot, 4 bits).
  - DIV_ITERS=32.
  - Special-result constants DIV0_QUO=32'hFFFFFFFF and OVF_QUO=32'h80000000.
- One sub-module, div_iter_step: combinational single restoring step. Inputs are rem[31:0], quo[31:0], divisor; outputs are next rem/quo. It is instantiated once inside div_seq.

Test Plan:
- Unsigned 100/7, div_op=00 -> res_valid exactly 34 cycles after accept, div_result=14; repeat with div_op=10 -> 2.
- Signed -7/2 (0xFFFFFFF9/2), div_op=01 -> 0xFFFFFFFD; div_op=11 -> 0xFFFFFFFF.
- Signed 0x80000000/0xFFFFFFFF, div_op=01 -> 0x80000000; div_op=11 -> 0; res_valid at T+2 with EARLY_ZERO=1, T+34 with EARLY_ZERO=0.
- 1234/0 unsigned, div_op=00 -> 0xFFFFFFFF; div_op=10 -> 1234 (0x4D2).
- Cancel at the 10th ITER cycle -> res_valid stays 0, div_ready=1 next cycle; a new 9/3 op is accepted and returns 3.
- res_ready held low 5 cycles after res_valid -> div_result stable and div_ready=0 throughout; res_ready pulse -> IDLE next cycle.
